// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared definitions for the iterative multiply/divide unit.
//   MD_WIDTH          default operand width (iteration count equals width)
//   OP_MULT / OP_DIV  operation codes
//   ST_* / state_e    FSM state encoding
package mult_div_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MULT = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIN  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    typedef enum logic [2:0] {
        StIdle = ST_IDLE,
        StMult = ST_MULT,
        StDiv  = ST_DIV,
        StFin  = ST_FIN,
        StErr  = ST_ERR
    } state_e;

endpackage

// File: rtl/mult_div_div_step.sv
// mult_div_div_step: one combinational restoring-division iteration on magnitudes.
// Ports:
//   rem_quo       in   2*WIDTH+1  {remainder (WIDTH+1), quotient/dividend shift reg (WIDTH)}
//   divisor       in   WIDTH+1    divisor magnitude
//   rem_quo_next  out  2*WIDTH+1  state after one shift/trial-subtract step
module mult_div_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH:0] rem_quo,
    input  logic [WIDTH:0]   divisor,
    output logic [2*WIDTH:0] rem_quo_next
);

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;

    assign rem = rem_quo[2*WIDTH:WIDTH];
    assign quo = rem_quo[WIDTH-1:0];

    // Shift the next dividend bit into the remainder; one spare bit keeps the trial sign exact.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign fits    = ~trial[WIDTH+1];

    always_comb begin
        rem_quo_next = {shifted[WIDTH:0], quo[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_quo_next = {trial[WIDTH:0], quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div.sv
// mult_div: iterative signed multiply/divide unit feeding the HI/LO registers.
// Ports:
//   clock       in   1      system clock, rising edge
//   reset       in   1      asynchronous active-low reset
//   start_mult  in   1      pulse: begin signed a*b (wins over start_div)
//   start_div   in   1      pulse: begin signed a/b
//   a, b        in   WIDTH  operands, latched when leaving idle
//   busy        out  1      operation in progress, through the done/div0 cycle
//   done        out  1      pulse: hi/lo hold the new result
//   div0        out  1      pulse: divisor was zero, hi/lo untouched
//   hi, lo      out  WIDTH  mult: product high/low; div: remainder/quotient
module mult_div
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AccW     = 2 * WIDTH + 1;
    localparam logic [5:0]  LastStep = 6'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [AccW-1:0]   acc_q, acc_d;
    // Mult: sign-extended multiplicand. Div: divisor magnitude (0x80000000 needs the extra bit).
    logic [WIDTH:0]    opb_q, opb_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic [WIDTH:0]    booth_upper;
    logic [WIDTH:0]    booth_sum;
    logic [AccW-1:0]   booth_next;
    logic [AccW-1:0]   div_next;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH:0]    b_mag;
    logic [WIDTH-1:0]  quo_mag;
    logic [WIDTH-1:0]  rem_mag;
    logic              last_step;

    assign last_step = (cnt_q == LastStep);

    // Booth step: accumulator is {upper(WIDTH), multiplier(WIDTH), q_-1}. The add is done one bit
    // wider so the arithmetic shift keeps the true sign even for a multiplicand of -2^(WIDTH-1).
    assign booth_upper = {acc_q[AccW-1], acc_q[AccW-1 -: WIDTH]};

    always_comb begin
        booth_sum = booth_upper;
        unique case (acc_q[1:0])
            2'b01:   booth_sum = booth_upper + opb_q;
            2'b10:   booth_sum = booth_upper - opb_q;
            default: booth_sum = booth_upper;
        endcase
    end

    assign booth_next = {booth_sum, acc_q[WIDTH:1]};

    mult_div_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_quo      (acc_q),
        .divisor      (opb_q),
        .rem_quo_next (div_next)
    );

    assign a_mag   = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag   = b[WIDTH-1] ? ({1'b0, ~b} + 1'b1) : {1'b0, b};
    assign quo_mag = div_next[WIDTH-1:0];
    assign rem_mag = div_next[2*WIDTH-1:WIDTH];

    // Results are written on the final step edge so hi/lo are already valid during the done cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_mult) begin
                    state_d = StMult;
                    acc_d   = {{WIDTH{1'b0}}, b, 1'b0};
                    opb_d   = {a[WIDTH-1], a};
                end else if (start_div) begin
                    state_d = (b == '0) ? StErr : StDiv;
                    a_neg_d = a[WIDTH-1];
                    b_neg_d = b[WIDTH-1];
                    acc_d   = {{(WIDTH + 1){1'b0}}, a_mag};
                    opb_d   = b_mag;
                end
            end
            StMult: begin
                acc_d = booth_next;
                cnt_d = cnt_q + 6'd1;
                if (last_step) begin
                    state_d = StFin;
                    cnt_d   = '0;
                    hi_d    = booth_next[AccW-1 -: WIDTH];
                    lo_d    = booth_next[WIDTH:1];
                end
            end
            StDiv: begin
                acc_d = div_next;
                cnt_d = cnt_q + 6'd1;
                if (last_step) begin
                    state_d = StFin;
                    cnt_d   = '0;
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    lo_d    = (a_neg_q ^ b_neg_q) ? (~quo_mag + 1'b1) : quo_mag;
                    hi_d    = a_neg_q ? (~rem_mag + 1'b1) : rem_mag;
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StFin);
    assign div0 = (state_q == StErr);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed vectors for mult_div with an arithmetic reference model checked every
// cycle, plus literal expectations for results and latency.
module tb_mult_div;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic          start_mult;
    logic          start_div;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          div0;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int tests;
    int errors;
    logic chk_en;

    mult_div #(
        .WIDTH (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div0       (div0),
        .hi         (hi),
        .lo         (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference results from plain 64-bit signed arithmetic.
    function automatic logic [63:0] ref_result(input logic is_div, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint lx;
        longint ly;
        longint q;
        longint r;
        logic [63:0] p;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        if (!is_div) begin
            p = lx * ly;
            return p;
        end
        q = lx / ly;
        r = lx % ly;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: an accepted op runs for W cycles after its start edge, then one done cycle;
    // a zero divisor gives a div0 cycle straight away.
    logic          m_active;
    int            m_cnt;
    logic          m_err;
    logic [W-1:0]  m_hi;
    logic [W-1:0]  m_lo;
    logic [63:0]   m_pend;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_err    <= 1'b0;
            m_hi     <= '0;
            m_lo     <= '0;
            m_pend   <= '0;
        end else if (m_active) begin
            if (m_cnt == 0) begin
                m_active <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !m_err) begin
                    m_hi <= m_pend[63:32];
                    m_lo <= m_pend[31:0];
                end
            end
        end else if (start_mult || start_div) begin
            m_active <= 1'b1;
            if (start_mult) begin
                m_err  <= 1'b0;
                m_cnt  <= W;
                m_pend <= ref_result(1'b0, a, b);
            end else if (b == '0) begin
                m_err <= 1'b1;
                m_cnt <= 0;
            end else begin
                m_err  <= 1'b0;
                m_cnt  <= W;
                m_pend <= ref_result(1'b1, a, b);
            end
        end
    end

    always @(negedge clock) begin
        if (reset && chk_en) begin
            check("model_busy", {63'd0, busy}, {63'd0, m_active});
            check("model_done", {63'd0, done}, {63'd0, m_active && m_cnt == 0 && !m_err});
            check("model_div0", {63'd0, div0}, {63'd0, m_active && m_cnt == 0 && m_err});
            check("model_hilo", {hi, lo}, {m_hi, m_lo});
        end
    end

    // Issue one op, track the cycle its done/div0 shows, then check literals.
    task automatic run_op(input string nm, input logic is_div, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic eerr);
        int lat;
        logic saw_err;
        lat = -1;
        saw_err = 1'b0;
        @(posedge clock);
        #1;
        a = av;
        b = bv;
        start_mult = !is_div;
        start_div  = is_div;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clock);
            #1;
            start_mult = 1'b0;
            start_div  = 1'b0;
            a = $urandom;
            b = $urandom;
            @(negedge clock);
            if (done || div0) begin
                lat = k;
                saw_err = div0;
                check({nm, "_exclusive"}, {63'd0, done & div0}, 64'd0);
            end
        end
        check({nm, "_latency"}, 64'(lat), eerr ? 64'd1 : 64'd33);
        check({nm, "_div0"}, {63'd0, saw_err}, {63'd0, eerr});
        check({nm, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({nm, "_lo"}, {32'd0, lo}, {32'd0, elo});
    endtask

    int n_done;
    int n_div0;

    initial begin
        tests = 0;
        errors = 0;
        chk_en = 1'b0;
        reset = 1'b0;
        start_mult = 1'b0;
        start_div = 1'b0;
        a = '0;
        b = '0;
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_div0", {63'd0, div0}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        chk_en = 1'b1;

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_by_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
        run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // A start_div arriving mid-multiply is ignored.
        n_done = 0;
        n_div0 = 0;
        @(posedge clock);
        #1;
        a = 32'd3;
        b = 32'd5;
        start_mult = 1'b1;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        start_div = 1'b1;
        b = 32'd0;
        @(posedge clock);
        #1;
        start_div = 1'b0;
        repeat (45) begin
            @(negedge clock);
            if (done) n_done++;
            if (div0) n_div0++;
        end
        check("ignore_done_count", 64'(n_done), 64'd1);
        check("ignore_div0_count", 64'(n_div0), 64'd0);
        check("ignore_hilo", {hi, lo}, {32'd0, 32'd15});

        // Reset in the middle of an op aborts it at once.
        @(posedge clock);
        #1;
        a = 32'h1234_5678;
        b = 32'd3;
        start_mult = 1'b1;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        #1;
        reset = 1'b1;
        n_done = 0;
        n_div0 = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) n_done++;
            if (div0) n_div0++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_no_div0", 64'(n_div0), 64'd0);

        run_op("mul_after_abort", 1'b0, 32'hFFFF_FFF0, 32'd16, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
